// File: rtl/uart_rx_cfg_pkg.sv
// +----------------------------------------------------------------------+
// | uart_rx_cfg_pkg                                                      |
// | Parity codes, receiver state encodings and clog2 shared by FWU UART. |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_rx_cfg_pkg;

  localparam int FWU_PAR_NONE = 0;
  localparam int FWU_PAR_EVEN = 1;
  localparam int FWU_PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } rx_state_t;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// +----------------------------------------------------------------------+
// | uart_rx_sampler                                                      |
// | 2-flop rx synchroniser, per-bit timer and 3-tap majority vote.       |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_rx_sampler
  import uart_rx_cfg_pkg::*;
#(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic restart,
  output logic rx_s,
  output logic bit_vote,
  output logic vote_stb,
  output logic end_stb
);

  localparam int            c_cnt_w = clog2(DIV);
  localparam logic [c_cnt_w-1:0] c_half = c_cnt_w'(DIV / 2);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIV - 1);

  logic [1:0]         r_sync;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_s0;
  logic               r_s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 2'b11;
      r_cnt  <= '0;
      r_s0   <= 1'b1;
      r_s1   <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], rx};
      if (restart || r_cnt == c_last) r_cnt <= '0;
      else                            r_cnt <= r_cnt + 1'b1;
      if (r_cnt == c_half - 1'b1) r_s0 <= rx_s;
      if (r_cnt == c_half)        r_s1 <= rx_s;
    end
  end

  // Third tap is the live synchronised line at cnt = H+1.
  assign rx_s     = r_sync[1];
  assign bit_vote = (r_s0 & r_s1) | (r_s0 & rx_s) | (r_s1 & rx_s);
  assign vote_stb = (r_cnt == c_half + 1'b1);
  assign end_stb  = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/uart_rx_cfg.sv
// +----------------------------------------------------------------------+
// | uart_rx_cfg                                                          |
// | Configurable UART receiver with error flags and valid/ready output.  |
// | Optional break detector: define FWU_UART_BREAK_EN.                   |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 921600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 brk
);

  localparam int         c_div       = (CLK_HZ + BAUD / 2) / BAUD;
  localparam logic [3:0] c_data_bits = 4'(DATA_BITS);
  localparam logic [3:0] c_last_stop = 4'(STOP_BITS - 1);

  rx_state_t r_state, w_next;
  logic                 w_rx_s, w_bit, w_vote_stb, w_end_stb, w_restart;
  logic                 w_done, w_brk_hit, w_par_calc, w_perr;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic [3:0]           r_bitcnt;
  logic                 r_pbit, r_ferr, r_valid, r_fe_out, r_pe_out, r_overrun;

  uart_rx_sampler #(.DIV(c_div)) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .restart  (w_restart),
    .rx_s     (w_rx_s),
    .bit_vote (w_bit),
    .vote_stb (w_vote_stb),
    .end_stb  (w_end_stb)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

`ifdef FWU_UART_BREAK_EN
  logic r_zero;
  logic r_brk;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero <= 1'b0;
      r_brk  <= 1'b0;
    end else begin
      r_brk <= w_brk_hit;
      if (r_state == ST_START) r_zero <= 1'b1;
      else if (w_vote_stb && (r_state == ST_DATA || r_state == ST_PARITY))
        r_zero <= r_zero & ~w_bit;
    end
  end

  assign brk = r_brk;
`else
  assign brk = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_restart = 1'b0;
    w_done    = 1'b0;
    w_brk_hit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_restart = 1'b1;
        if (!w_rx_s) w_next = ST_START;
      end
      ST_START: begin
        if (w_vote_stb && w_bit) w_next = ST_IDLE;
        else if (w_end_stb)      w_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_end_stb && r_bitcnt == c_data_bits)
          w_next = (PARITY == FWU_PAR_NONE) ? ST_STOP : ST_PARITY;
      end
      ST_PARITY: begin
        if (w_end_stb) w_next = ST_STOP;
      end
      ST_STOP: begin
        // Final stop vote ends the frame mid-bit so back-to-back starts are caught.
        if (w_vote_stb) begin
`ifdef FWU_UART_BREAK_EN
          if (r_bitcnt == 4'd0 && r_zero && !w_bit) begin
            w_brk_hit = 1'b1;
            w_next    = ST_BRK_WAIT;
          end else
`endif
          if (r_bitcnt == c_last_stop) begin
            w_done = 1'b1;
            w_next = ST_IDLE;
          end
        end
      end
`ifdef FWU_UART_BREAK_EN
      ST_BRK_WAIT: begin
        w_restart = 1'b1;
        if (w_rx_s) w_next = ST_IDLE;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_par_calc = (^r_shift) ^ r_pbit;
  assign w_perr     = (PARITY == FWU_PAR_EVEN) ? w_par_calc :
                      (PARITY == FWU_PAR_ODD)  ? ~w_par_calc : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_pbit   <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      // Bit counter serves both data bits and stop bits; any state change clears it.
      if (w_next != r_state)
        r_bitcnt <= '0;
      else if (w_vote_stb && (r_state == ST_DATA || r_state == ST_STOP))
        r_bitcnt <= r_bitcnt + 4'd1;
      if (r_state == ST_START) r_ferr <= 1'b0;
      if (w_vote_stb) begin
        if (r_state == ST_DATA)   r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
        if (r_state == ST_PARITY) r_pbit  <= w_bit;
        if (r_state == ST_STOP && !w_bit) r_ferr <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_fe_out  <= 1'b0;
      r_pe_out  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_done) begin
        if (!r_valid || ready) begin
          r_data   <= r_shift;
          r_fe_out <= r_ferr | ~w_bit;
          r_pe_out <= w_perr;
          r_valid  <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign frame_err  = r_fe_out;
  assign parity_err = r_pe_out;
  assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
// +----------------------------------------------------------------------+
// | tb_uart_rx_cfg                                                       |
// | Directed bench: 8N1 instance (DIV 54) and 7E2 instance (DIV 16).     |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx_cfg;

  localparam int DIV_A = 54;
  localparam int DIV_B = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic ready_a = 1'b1, ready_b = 1'b1;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic valid_a, frame_err_a, parity_err_a, overrun_a, brk_a;
  logic valid_b, frame_err_b, parity_err_b, overrun_b, brk_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_HZ(50000000), .BAUD(921600), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .data(data_a), .valid(valid_a), .ready(ready_a),
    .frame_err(frame_err_a), .parity_err(parity_err_a), .overrun(overrun_a), .brk(brk_a)
  );

  uart_rx_cfg #(.CLK_HZ(8000000), .BAUD(500000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .data(data_b), .valid(valid_b), .ready(ready_b),
    .frame_err(frame_err_b), .parity_err(parity_err_b), .overrun(overrun_b), .brk(brk_b)
  );

  // Accepted-word logs and pulse counters
  logic [15:0] wa_data [64];
  logic        wa_fe   [64];
  logic        wa_pe   [64];
  logic [15:0] wb_data [64];
  logic        wb_fe   [64];
  logic        wb_pe   [64];
  int na = 0, nb = 0, vcyc_a = 0, ovr_a = 0, brk_cnt = 0;

  always @(negedge clk) begin
    if (valid_a) vcyc_a++;
    if (overrun_a) ovr_a++;
    if (brk_a) brk_cnt++;
    if (valid_a && ready_a && na < 64) begin
      wa_data[na] = 16'(data_a);
      wa_fe[na]   = frame_err_a;
      wa_pe[na]   = parity_err_a;
      na++;
    end
    if (valid_b && ready_b && nb < 64) begin
      wb_data[nb] = 16'(data_b);
      wb_fe[nb]   = frame_err_b;
      wb_pe[nb]   = parity_err_b;
      nb++;
    end
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // bits[] is the whole frame, LSB first; corrupt[] flips the middle sample point of that bit.
  task automatic send(input int sel, input logic [15:0] bits, input int n, input logic [15:0] corrupt);
    int   div;
    logic v;
    div = (sel == 0) ? DIV_A : DIV_B;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < div; c++) begin
        v = bits[i] ^ (corrupt[i] && (c == div / 2 + 1));
        if (sel == 0) rx_a = v; else rx_b = v;
        @(posedge clk); #1;
      end
    end
    if (sel == 0) rx_a = 1'b1; else rx_b = 1'b1;
    repeat (2 * div) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] fr8(input logic [7:0] d);
    return {7'b0, 1'b1, d, 1'b0};
  endfunction

  function automatic logic [15:0] fr7(input logic [6:0] d, input logic p, input logic s1, input logic s2);
    return {5'b0, s2, s1, p, d, 1'b0};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int na0, v0, o0, b0, nb0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_data",   16'(data_a), 16'h0);
    check_eq("rst_valid",  16'(valid_a), 16'h0);
    check_eq("rst_fe",     16'(frame_err_a), 16'h0);
    check_eq("rst_pe",     16'(parity_err_a), 16'h0);
    check_eq("rst_ovr",    16'(overrun_a), 16'h0);
    check_eq("rst_brk",    16'(brk_a), 16'h0);
    check_eq("rst_valid_b", 16'(valid_b), 16'h0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // 8N1 basic frame with ready high: single-cycle valid
    v0 = vcyc_a;
    send(0, fr8(8'hA5), 10, 16'h0);
    check_eq("a5_count", 16'(na), 16'd1);
    check_eq("a5_data",  wa_data[0], 16'h00A5);
    check_eq("a5_fe",    16'(wa_fe[0]), 16'h0);
    check_eq("a5_pe",    16'(wa_pe[0]), 16'h0);
    check_eq("a5_vcyc",  16'(vcyc_a - v0), 16'd1);

    send(0, fr8(8'h3C), 10, 16'h0);
    check_eq("3c_data",  wa_data[1], 16'h003C);

    // Short start glitch must be rejected
    na0 = na;
    rx_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx_a = 1'b1;
    repeat (12 * DIV_A) @(posedge clk);
    #1;
    check_eq("glitch_nowords", 16'(na - na0), 16'd0);

    // One sample per data bit corrupted; majority restores the word
    send(0, fr8(8'h96), 10, 16'h01FE);
    check_eq("maj_data", wa_data[na - 1], 16'h0096);
    check_eq("maj_fe",   16'(wa_fe[na - 1]), 16'h0);

    // Overrun: second word dropped while first is pending
    ready_a = 1'b0;
    o0 = ovr_a;
    na0 = na;
    send(0, fr8(8'h11), 10, 16'h0);
    send(0, fr8(8'h22), 10, 16'h0);
    check_eq("ovr_data",  16'(data_a), 16'h0011);
    check_eq("ovr_valid", 16'(valid_a), 16'h1);
    check_eq("ovr_pulse", 16'(ovr_a - o0), 16'd1);
    ready_a = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ovr_drain_valid", 16'(valid_a), 16'h0);
    check_eq("ovr_drain_count", 16'(na - na0), 16'd1);
    check_eq("ovr_drain_data",  wa_data[na - 1], 16'h0011);

    // Reset in the middle of a frame with a word pending
    ready_a = 1'b0;
    send(0, fr8(8'h77), 10, 16'h0);
    check_eq("pend_data", 16'(data_a), 16'h0077);
    rx_a = 1'b0;
    repeat (3 * DIV_A) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_valid", 16'(valid_a), 16'h0);
    check_eq("mid_rst_data",  16'(data_a), 16'h0);
    rst = 1'b0;
    rx_a = 1'b1;
    ready_a = 1'b1;
    na0 = na;
    repeat (12 * DIV_A) @(posedge clk);
    #1;
    check_eq("mid_rst_nowords", 16'(na - na0), 16'd0);

    // 7E2: parity and second-stop framing
    nb0 = nb;
    send(1, fr7(7'h41, 1'b1, 1'b1, 1'b1), 11, 16'h0);
    check_eq("b_bad_par_count", 16'(nb - nb0), 16'd1);
    check_eq("b_bad_par_data",  wb_data[nb - 1], 16'h0041);
    check_eq("b_bad_par_pe",    16'(wb_pe[nb - 1]), 16'h1);
    send(1, fr7(7'h41, 1'b0, 1'b1, 1'b1), 11, 16'h0);
    check_eq("b_good_par_pe",   16'(wb_pe[nb - 1]), 16'h0);
    check_eq("b_good_par_fe",   16'(wb_fe[nb - 1]), 16'h0);
    send(1, fr7(7'h2A, 1'b1, 1'b1, 1'b0), 11, 16'h0);
    check_eq("b_stop2_fe",      16'(wb_fe[nb - 1]), 16'h1);
    check_eq("b_stop2_data",    wb_data[nb - 1], 16'h002A);
    nb0 = nb;
    send(1, fr7(7'h15, 1'b1, 1'b1, 1'b1), 11, 16'h0);
    check_eq("b_after_count",   16'(nb - nb0), 16'd1);
    check_eq("b_after_data",    wb_data[nb - 1], 16'h0015);
    check_eq("b_after_fe",      16'(wb_fe[nb - 1]), 16'h0);

    // Line held low for 12 bit periods
    na0 = na;
    b0 = brk_cnt;
    rx_a = 1'b0;
    repeat (12 * DIV_A) @(posedge clk);
    #1;
    rx_a = 1'b1;
    repeat (12 * DIV_A) @(posedge clk);
    #1;
`ifdef FWU_UART_BREAK_EN
    check_eq("brk_pulse",   16'(brk_cnt - b0), 16'd1);
    check_eq("brk_nowords", 16'(na - na0), 16'd0);
`else
    check_eq("zero_brk",  16'(brk_cnt - b0), 16'd0);
    check_eq("zero_word", 16'(na > na0), 16'd1);
    check_eq("zero_data", wa_data[na0], 16'h0000);
    check_eq("zero_fe",   16'(wa_fe[na0]), 16'h1);
`endif
    send(0, fr8(8'h5A), 10, 16'h0);
    check_eq("post_low_data", wa_data[na - 1], 16'h005A);
    check_eq("post_low_fe",   16'(wa_fe[na - 1]), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
